// File: rtl/corefifo_ptr_sync.sv
// Multi-channel synchroniser for Gray-coded FIFO pointers, with a registered binary decode and a change pulse.
// Optional Gray-step checker enabled by defining SYNC_GRAY_CHECK_EN; otherwise gray_err is tied low.
module corefifo_ptr_sync #(
    parameter int NUM_STAGES = 2,
    parameter int ADDRWIDTH  = 3,
    parameter int NUM_CH     = 1
) (
    input  logic                            clk,
    input  logic                            srst,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0] inp,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_out,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] bin_out,
    output logic [NUM_CH-1:0]               chg,
    output logic [NUM_CH-1:0]               gray_err
);

    localparam int PW = ADDRWIDTH + 1;

    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0] stage [NUM_STAGES];
        logic [PW-1:0] bin_q;
        logic [PW-1:0] bin_next;
        logic          chg_q;

        always_comb begin
            bin_next = gray_to_bin(stage[NUM_STAGES-1]);
        end

        // chg is registered together with bin_out so the pulse lines up with the new value.
        always_ff @(posedge clk) begin
            if (srst) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    stage[k] <= '0;
                end
                bin_q <= '0;
                chg_q <= 1'b0;
            end else begin
                stage[0] <= inp[c*PW +: PW];
                for (int k = 1; k < NUM_STAGES; k++) begin
                    stage[k] <= stage[k-1];
                end
                bin_q <= bin_next;
                chg_q <= (bin_next != bin_q);
            end
        end

        assign sync_out[c*PW +: PW] = stage[NUM_STAGES-1];
        assign bin_out[c*PW +: PW]  = bin_q;
        assign chg[c]               = chg_q;

`ifdef SYNC_GRAY_CHECK_EN
        localparam logic [PW-1:0] ONE = PW'(1);
        logic [PW-1:0] prev_q;
        logic [PW-1:0] diff;
        logic          err_q;

        always_comb begin
            diff = stage[NUM_STAGES-1] ^ prev_q;
        end

        // More than one bit set in diff (x & (x-1) nonzero) is an illegal Gray step.
        always_ff @(posedge clk) begin
            if (srst) begin
                prev_q <= '0;
                err_q  <= 1'b0;
            end else begin
                prev_q <= stage[NUM_STAGES-1];
                if ((diff & (diff - ONE)) != '0) begin
                    err_q <= 1'b1;
                end
            end
        end

        assign gray_err[c] = err_q;
`else
        assign gray_err[c] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_corefifo_ptr_sync.sv
// Self-checking bench for corefifo_ptr_sync: directed latency/wrap/reset/multi-channel steps plus a random phase
// checked every cycle against a sample-history reference model.
`timescale 1ns/1ps
module tb_corefifo_ptr_sync;

    localparam int NS  = 3;
    localparam int AW  = 3;
    localparam int NCH = 4;
    localparam int W   = AW + 1;
    localparam int VW  = NCH * W;
`ifdef SYNC_GRAY_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic           clk  = 1'b0;
    logic           srst = 1'b1;
    logic [VW-1:0]  inp  = '0;
    logic [VW-1:0]  sync_out;
    logic [VW-1:0]  bin_out;
    logic [NCH-1:0] chg;
    logic [NCH-1:0] gray_err;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0]   hist [NCH][NS+2];
    logic [NCH-1:0] m_err = '0;

    corefifo_ptr_sync #(
        .NUM_STAGES(NS),
        .ADDRWIDTH (AW),
        .NUM_CH    (NCH)
    ) dut (
        .clk     (clk),
        .srst    (srst),
        .inp     (inp),
        .sync_out(sync_out),
        .bin_out (bin_out),
        .chg     (chg),
        .gray_err(gray_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // hist[c][k] is the input channel c presented k+1 edges ago, zeroed by reset.
    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (srst) begin
                for (int k = 0; k < NS + 2; k++) hist[c][k] = '0;
                m_err[c] = 1'b0;
            end else begin
                for (int k = NS + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = inp[c*W +: W];
                if (ERR_EN && $countones(hist[c][NS] ^ hist[c][NS+1]) > 1) m_err[c] = 1'b1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        logic [VW-1:0]  es;
        logic [VW-1:0]  eb;
        logic [NCH-1:0] ec;
        for (int c = 0; c < NCH; c++) begin
            es[c*W +: W] = hist[c][NS-1];
            eb[c*W +: W] = g2b(hist[c][NS]);
            ec[c]        = (g2b(hist[c][NS]) != g2b(hist[c][NS+1]));
        end
        check_val("model_sync", 32'(sync_out), 32'(es));
        check_val("model_bin",  32'(bin_out),  32'(eb));
        check_val("model_chg",  32'(chg),      32'(ec));
        check_val("model_err",  32'(gray_err), 32'(m_err));
    endtask

    task automatic tick();
        @(negedge clk);
        check_output();
    endtask

    task automatic apply_stimulus(input int c, input logic [W-1:0] v);
        inp[c*W +: W] = v;
    endtask

    initial begin
        int pulses;
        logic [W-1:0] last_bin;
        logic [W-1:0] wrap_prev;
        logic [W-1:0] g;

        $display("[TB] start NS=%0d NCH=%0d ERR_EN=%0d", NS, NCH, ERR_EN);
        srst = 1'b1;
        @(negedge clk);
        repeat (3) tick();
        check_val("reset_sync", 32'(sync_out), 32'd0);
        check_val("reset_bin",  32'(bin_out),  32'd0);
        check_val("reset_chg",  32'(chg),      32'd0);
        check_val("reset_err",  32'(gray_err), 32'd0);
        srst = 1'b0;

        // Latency and illegal-step checker: 0000 -> 0011 on channel 0.
        apply_stimulus(0, 4'b0011);
        repeat (NS - 1) tick();
        check_val("lat_sync_early", 32'(sync_out[W-1:0]), 32'd0);
        tick();
        check_val("lat_sync", 32'(sync_out[W-1:0]), 32'b0011);
        check_val("lat_bin_early", 32'(bin_out[W-1:0]), 32'd0);
        check_val("lat_err_early", 32'(gray_err[0]), 32'd0);
        tick();
        check_val("lat_bin", 32'(bin_out[W-1:0]), 32'd2);
        check_val("lat_chg", 32'(chg), 32'b0001);
        check_val("lat_err", 32'(gray_err[0]), 32'(ERR_EN));
        tick();
        check_val("lat_chg_off", 32'(chg), 32'd0);
        repeat (4) tick();
        check_val("err_sticky", 32'(gray_err[0]), 32'(ERR_EN));

        srst = 1'b1;
        tick();
        check_val("rst_clears_err", 32'(gray_err), 32'd0);
        check_val("rst_clears_bin", 32'(bin_out), 32'd0);
        apply_stimulus(0, 4'b0000);
        tick();
        srst = 1'b0;

        // Wrap-around: Gray of 1..15 then 0, one step every 4 cycles.
        pulses    = 0;
        last_bin  = '0;
        wrap_prev = '1;
        for (int s = 1; s <= 16; s++) begin
            apply_stimulus(0, b2g(W'(s % 16)));
            for (int k = 0; k < 4 + ((s == 16) ? NS + 2 : 0); k++) begin
                tick();
                if (chg[0]) begin
                    pulses++;
                    if (bin_out[W-1:0] == '0) wrap_prev = last_bin;
                end
                last_bin = bin_out[W-1:0];
            end
        end
        check_val("wrap_pulses", 32'(pulses), 32'd16);
        check_val("wrap_from", 32'(wrap_prev), 32'd15);
        check_val("wrap_bin_end", 32'(bin_out[W-1:0]), 32'd0);
        check_val("wrap_err", 32'(gray_err), 32'd0);

        // Reset mid-flight: new value enters stage 0, then reset discards it.
        apply_stimulus(0, 4'b0001);
        tick();
        srst = 1'b1;
        tick();
        check_val("mid_sync", 32'(sync_out), 32'd0);
        check_val("mid_bin",  32'(bin_out),  32'd0);
        check_val("mid_chg",  32'(chg),      32'd0);
        check_val("mid_err",  32'(gray_err), 32'd0);
        srst = 1'b0;
        repeat (NS) tick();
        check_val("mid_bin_early", 32'(bin_out[W-1:0]), 32'd0);
        tick();
        check_val("mid_bin_back", 32'(bin_out[W-1:0]), 32'd1);
        check_val("mid_chg_pulse", 32'(chg), 32'b0001);
        tick();
        check_val("mid_chg_off", 32'(chg), 32'd0);

        // Multi-channel: channels 1 and 3 settle, then 0 and 2 step together.
        apply_stimulus(1, b2g(4'd5));
        apply_stimulus(3, b2g(4'd9));
        repeat (NS + 3) tick();
        apply_stimulus(0, b2g(4'd2));
        apply_stimulus(2, b2g(4'd1));
        repeat (NS) tick();
        check_val("mc_chg_early", 32'(chg), 32'd0);
        tick();
        check_val("mc_chg", 32'(chg), 32'b0101);
        tick();
        check_val("mc_chg_off", 32'(chg), 32'd0);

        // Random phase: mostly legal Gray steps and holds, occasional arbitrary jumps and resets.
        for (int t = 0; t < 300; t++) begin
            for (int c = 0; c < NCH; c++) begin
                int r;
                r = $urandom_range(0, 99);
                g = inp[c*W +: W];
                if (r < 30) g = b2g(g2b(g) + W'(1));
                else if (r < 40) g = b2g(g2b(g) - W'(1));
                else if (r < 45) g = W'($urandom_range(0, (1 << W) - 1));
                apply_stimulus(c, g);
            end
            srst = ($urandom_range(0, 99) < 3);
            tick();
        end
        srst = 1'b0;
        repeat (NS + 3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/corefifo_ptr_sync.md
CORefifo_PTR_SYNC -- requirements
Module: corefifo_ptr_sync

Interface
REQ-001 Parameter NUM_STAGES, default 2: synchroniser depth in flops per channel, legal range 2..4.
REQ-002 Parameter ADDRWIDTH, default 3: each channel's pointer is ADDRWIDTH+1 bits wide.
REQ-003 Parameter NUM_CH, default 1: number of independent pointer channels, legal range 1..8.
REQ-004 clk  input  1: the single clock; all flops sample on its rising edge.
REQ-005 srst  input  1: reset, synchronous, active-high.
REQ-006 inp  input  NUM_CH*(ADDRWIDTH+1): Gray-coded pointers from the foreign domain; channel c occupies bits [c*(ADDRWIDTH+1) +: ADDRWIDTH+1].
REQ-007 sync_out  output  NUM_CH*(ADDRWIDTH+1): synchronised Gray value, taken from the last stage.
REQ-008 bin_out  output  NUM_CH*(ADDRWIDTH+1): registered binary decode of sync_out.
REQ-009 chg  output  NUM_CH: single-cycle pulse per channel, asserted when bin_out changes value.
REQ-010 gray_err  output  NUM_CH: sticky per-channel flag indicating an illegal Gray step.

Function
REQ-011 Each channel shall have NUM_STAGES cascaded flops; stage 0 samples inp and stage k samples stage k-1.
REQ-012 sync_out shall equal the inp value sampled NUM_STAGES rising edges earlier (latency = NUM_STAGES).
REQ-013 bin_out shall be registered, with latency NUM_STAGES+1 from inp.
- MSB: bin_out = sync_out.
- Bit i: bin_out[i] = bin_out[i+1] XOR sync_out[i].
REQ-014 chg[c] shall be high for exactly one cycle, in the same cycle a new bin_out value becomes visible, when that value differs from the previous bin_out.
REQ-015 chg[c] shall stay low when bin_out is unchanged, including when the input is held constant.
REQ-016 Wrap-around shall be treated as an ordinary change.
- Example, ADDRWIDTH=3: Gray 4'b1000 (bin 15) to Gray 4'b0000 (bin 0) shall pulse chg with no error.
REQ-017 Channels shall be fully independent; simultaneous changes on several channels shall produce simultaneous chg pulses.
REQ-018 Since each stage reloads every cycle, an input held for at least one clock shall always propagate.
REQ-019 Input changes shorter than one clock may be lost; this is legal.

Reset
REQ-020 While srst is sampled high, the next rising edge shall clear the following to zero:
- all stage flops
- sync_out
- bin_out
- chg
- gray_err
REQ-021 A reset asserted mid-operation shall discard all in-flight values, with no partial propagation.
REQ-022 After srst is released, the first valid sync_out shall appear NUM_STAGES edges later, and the first valid bin_out NUM_STAGES+1 edges later.
REQ-023 If the input is nonzero after reset release, chg shall pulse once when bin_out first leaves zero.
REQ-024 srst shall take priority over every other event in the same cycle.

Configuration
REQ-025 Macro SYNC_GRAY_CHECK_EN shall select the Gray-step checker.
- Defined: a per-channel register holds the previous sync_out value.
- gray_err[c] shall set, one cycle after sync_out, when two consecutive sync_out values differ in more than one bit.
- gray_err[c] shall remain set until srst.
- Undefined: gray_err shall be tied to zero, and no checker or previous-value logic shall be instantiated.
REQ-026 chg, bin_out and sync_out shall behave identically with and without SYNC_GRAY_CHECK_EN.

Verification
REQ-027 Latency, with NUM_STAGES=2 and ADDRWIDTH=3: hold srst for 3 cycles, release, drive inp=4'b0011 (bin 2) at edge 0.
- Expected: sync_out=4'b0011 after edge 2, bin_out=4'd2 after edge 3, and a single chg pulse in the cycle after edge 3.
REQ-028 Wrap-around: step inp through Gray 0..15 then back to 0, one value every 4 cycles.
- Expected: 16 chg pulses, bin_out wraps from 15 to 0, and gray_err stays 0.
REQ-029 Gray checker, with SYNC_GRAY_CHECK_EN defined: jump inp from 4'b0000 to 4'b0011.
- Expected: gray_err goes to 1 NUM_STAGES+1 edges later and stays 1 until srst.
- Repeating the run with the macro undefined: gray_err stays 0 throughout.
REQ-030 Reset mid-flight: change inp from 0 to 4'b0001 and assert srst on the next edge for 1 cycle.
- Expected: all outputs are 0 one edge later.
- With inp held, bin_out=1 reappears NUM_STAGES+1 edges after release, with one chg pulse.
REQ-031 Multi-channel, with NUM_CH=4 and NUM_STAGES=3: change channels 0 and 2 in the same cycle and hold channels 1 and 3.
- Expected: chg=4'b0101 for exactly one cycle, 4 edges after the change.
